trakball_emu: RTL and testbench
===============================

Name: trakball_emu

Overview:
- Emulates the Centipede trackball from digital controls (keyboard/joystick directions already decoded in the top level).
- Produces the 8-bit trakball_i word consumed by the centipede game core, replacing the constant-zero tie-off.
- Two independent axes, each a 4-bit wrapping position counter plus a direction flag.
- Movement is rate-limited by a prescaled tick, with acceleration while a direction is held.

Parameters:
- TICK_DIV, 12000, clk_sys cycles per movement tick (1 kHz at 12 MHz); minimum 2.
- ACCEL_TICKS, 16, consecutive moving ticks on one axis before that axis's speed increments.
- MAX_SPEED, 4, saturation value of per-axis speed in counts/tick; range 1..15.

Ports:
- clk_sys  in  1  system clock (12 MHz game clock domain).
- reset_n  in  1  asynchronous active-low reset.
- enable_i  in  1  1 = emulation active; 0 = freeze positions.
- left_i  in  1  active-high, horizontal negative.
- right_i  in  1  active-high, horizontal positive.
- up_i  in  1  active-high, vertical positive.
- down_i  in  1  active-high, vertical negative.
- trak_o  out  8  {v_cnt[3:0], h_cnt[3:0]}, drives centipede trakball_i.
- h_dir_o  out  1  horizontal direction: 1 = last move negative (left).
- v_dir_o  out  1  vertical direction: 1 = last move negative (down).
- tick_o  out  1  one-cycle pulse per movement tick (debug/bench).

Behaviour:
- Reset is asynchronous on reset_n low. All registers are cleared: prescaler=0, h_cnt=v_cnt=0, h_dir=v_dir=0, speed_h=speed_v=1, hold_h=hold_v=0, tick_o=0. Reset takes effect immediately mid-tick.
- Prescaler:
  - Counts 0..TICK_DIV-1, free-running regardless of enable_i.
  - tick_o=1 for exactly the cycle in which the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- Per-axis rule, evaluated on tick cycles only. For horizontal, neg=left_i and pos=right_i; vertical is identical with down_i/up_i.
  - IDLE condition (enable_i=0, or neg==pos, i.e. none or both pressed):
    - cnt and dir hold.
    - speed<=1, hold<=0.
  - MOVE condition (enable_i=1 and exactly one of neg/pos):
    - Reversal: if the requested direction differs from the current dir, the effective speed is 1 for this tick, and speed and hold restart (speed<=1, hold<=1).
    - Otherwise: cnt<=cnt+speed (pos) or cnt-speed (neg), modulo 16 (4-bit wrap, no saturation).
    - dir<=1 for neg, 0 for pos.
    - hold<=hold+1. When hold+1==ACCEL_TICKS: hold<=0 and speed<=min(speed+1, MAX_SPEED). The new speed applies from the next tick.
- Non-tick cycles: no axis state changes. Input changes between ticks are sampled only at the tick cycle (no latching of short presses).
- Latency: trak_o/dir outputs are registered and reflect a tick's update on the cycle after tick_o is high.
- Axes are fully independent; simultaneous horizontal and vertical movement is allowed.
- Outputs come straight from registers; no combinational path from inputs to outputs.

Test Plan:
- Parameters for all scenarios: TICK_DIV=4, ACCEL_TICKS=2, MAX_SPEED=3.
- Release reset, no inputs, 40 cycles -> tick_o pulses every 4th cycle; trak_o=8'h00, dirs 0 throughout.
- right_i held from reset -> h_cnt after ticks 1..8 = 1,2,4,6,9,12,15,2 (wrap); h_dir_o=0; v_cnt stays 0.
- left_i one tick from reset -> h_cnt=15, h_dir_o=1. Then right_i one tick -> h_cnt=0, h_dir_o=0, speed restarted at 1.
- up_i+down_i held 4 ticks after v_cnt=5 -> v_cnt stays 5 and speed resets. Then up_i alone -> v_cnt=6 on the next tick.
- right_i held to speed 3 then enable_i=0 for 3 ticks -> h_cnt frozen. Re-enable -> first move +1 (speed restarted).
- reset_n pulsed low mid-prescale with h_cnt=9 -> outputs 0 in the same cycle without a clock edge. Counting restarts, with the first tick 4 cycles after release.

Source files
------------

// File: rtl/trakball_emu.sv
// Centipede trackball emulation: turns held digital directions into the 8-bit
// {v_cnt, h_cnt} quadrature-position word, with tick rate limiting and per-axis acceleration.
module trakball_emu #(
    parameter int TICK_DIV    = 12000,
    parameter int ACCEL_TICKS = 16,
    parameter int MAX_SPEED   = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [7:0] trak_o,
    output logic       h_dir_o,
    output logic       v_dir_o,
    output logic       tick_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(ACCEL_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ARM  = PW'(TICK_DIV - 2);
    localparam logic [3:0]    SPD_MAX  = 4'(MAX_SPEED);

    typedef struct packed {
        logic [3:0]    cnt;
        logic          dir;
        logic [3:0]    spd;
        logic [HW-1:0] hold;
    } axis_t;

    localparam axis_t AXIS_RST = '{cnt: 4'd0, dir: 1'b0, spd: 4'd1, hold: '0};

    // One tick of axis movement; a reversal moves a single count and restarts acceleration.
    function automatic axis_t next_axis(axis_t a, logic en, logic neg, logic pos);
        axis_t      n;
        logic [3:0] step;
        n    = a;
        step = a.spd;
        if (!en || (neg == pos)) begin
            n.spd  = 4'd1;
            n.hold = '0;
        end else begin
            n.dir = neg;
            if (neg != a.dir) begin
                step   = 4'd1;
                n.spd  = 4'd1;
                n.hold = HW'(1);
            end else if (int'(a.hold) + 1 >= ACCEL_TICKS) begin
                n.hold = '0;
                n.spd  = (a.spd >= SPD_MAX) ? SPD_MAX : a.spd + 4'd1;
            end else begin
                n.hold = a.hold + HW'(1);
            end
            n.cnt = neg ? a.cnt - step : a.cnt + step;
        end
        return n;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    axis_t         h_q, h_d;
    axis_t         v_q, v_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        tick_d = (pre_q == PRE_ARM);
        h_d    = h_q;
        v_d    = v_q;
        if (tick_q) begin
            h_d = next_axis(h_q, enable_i, left_i, right_i);
            v_d = next_axis(v_q, enable_i, down_i, up_i);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= AXIS_RST;
            v_q    <= AXIS_RST;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
        end
    end

    assign trak_o  = {v_q.cnt, h_q.cnt};
    assign h_dir_o = h_q.dir;
    assign v_dir_o = v_q.dir;
    assign tick_o  = tick_q;

endmodule

// File: tb/tb_trakball_emu.sv
// Self-checking bench for trakball_emu: directed scenarios plus randomized holds
// compared against a tick-level arithmetic model of the trackball.
module tb_trakball_emu;

    localparam int TICK_DIV    = 4;
    localparam int ACCEL_TICKS = 2;
    localparam int MAX_SPEED   = 3;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable_i = 1'b1;
    logic       left_i = 1'b0, right_i = 1'b0, up_i = 1'b0, down_i = 1'b0;
    logic [7:0] trak_o;
    logic       h_dir_o, v_dir_o, tick_o;

    int checks = 0;
    int errors = 0;

    trakball_emu #(.TICK_DIV(TICK_DIV), .ACCEL_TICKS(ACCEL_TICKS), .MAX_SPEED(MAX_SPEED)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .enable_i(enable_i),
        .left_i  (left_i),
        .right_i (right_i),
        .up_i    (up_i),
        .down_i  (down_i),
        .trak_o  (trak_o),
        .h_dir_o (h_dir_o),
        .v_dir_o (v_dir_o),
        .tick_o  (tick_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: index 0 = horizontal, 1 = vertical; positions kept as 0..15 integers.
    int m_pre;
    int m_cnt[2], m_dir[2], m_spd[2], m_hold[2];

    task automatic model_axis(input int a, input logic neg, input logic pos);
        int want, step;
        if (!enable_i || neg == pos) begin
            m_spd[a]  = 1;
            m_hold[a] = 0;
        end else begin
            want = neg ? 1 : 0;
            step = (want != m_dir[a]) ? 1 : m_spd[a];
            m_cnt[a] = (m_cnt[a] + (neg ? -step : step) + 32) % 16;
            if (want != m_dir[a]) begin
                m_spd[a]  = 1;
                m_hold[a] = 1;
            end else begin
                m_hold[a] = m_hold[a] + 1;
                if (m_hold[a] == ACCEL_TICKS) begin
                    m_hold[a] = 0;
                    m_spd[a]  = (m_spd[a] + 1 > MAX_SPEED) ? MAX_SPEED : m_spd[a] + 1;
                end
            end
            m_dir[a] = want;
        end
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_pre = 0;
            for (int a = 0; a < 2; a++) begin
                m_cnt[a] = 0; m_dir[a] = 0; m_spd[a] = 1; m_hold[a] = 0;
            end
        end else if (m_pre == TICK_DIV - 1) begin
            m_pre = 0;
            model_axis(0, left_i, right_i);
            model_axis(1, down_i, up_i);
        end else begin
            m_pre = m_pre + 1;
        end
    end

    function automatic logic [10:0] model_vec();
        return {8'(m_cnt[1] * 16 + m_cnt[0]), 1'(m_dir[0]), 1'(m_dir[1]), 1'(m_pre == TICK_DIV - 1)};
    endfunction

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Returns at the falling edge after the tick's update has landed in the outputs.
    task automatic tick_settle();
        bit seen = 0;
        for (int i = 0; i < 2 * TICK_DIV + 2 && !seen; i++) begin
            @(negedge clk_sys);
            seen = (tick_o === 1'b1);
        end
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout: no tick_o within %0d cycles", 2 * TICK_DIV + 2);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({trak_o, h_dir_o, v_dir_o, tick_o} !== 11'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 000", {trak_o, h_dir_o, v_dir_o, tick_o});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle();
        int ticks = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_sys);
            checks++;
            if ({trak_o, h_dir_o, v_dir_o} !== 10'h0 || tick_o !== model_vec()[0]) begin
                errors++;
                $display("FAIL idle_cycle%0d: trak=%h dirs=%b%b tick=%b want 00/00/%b",
                         c, trak_o, h_dir_o, v_dir_o, tick_o, model_vec()[0]);
            end
            if (tick_o === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL idle_tick_count: got %0d want 10", ticks);
        end
    endtask

    task automatic test_accel();
        int exp_h[8] = '{1, 2, 4, 6, 9, 12, 15, 2};
        right_i = 1'b1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick_settle();
            checks++;
            if (trak_o !== {4'd0, 4'(exp_h[k])} || h_dir_o !== 1'b0) begin
                errors++;
                $display("FAIL accel_tick%0d: trak=%h hdir=%b want %h/0", k + 1, trak_o, h_dir_o, exp_h[k]);
            end
        end
        right_i = 1'b0;
    endtask

    task automatic test_reversal();
        int exp_h[4] = '{15, 0, 1, 3};
        int exp_d[4] = '{1, 0, 0, 0};
        do_reset();
        left_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick_settle();
            checks++;
            if (trak_o[3:0] !== 4'(exp_h[k]) || h_dir_o !== 1'(exp_d[k])) begin
                errors++;
                $display("FAIL reversal_step%0d: h=%0d hdir=%b want %0d/%0d",
                         k, trak_o[3:0], h_dir_o, exp_h[k], exp_d[k]);
            end
            left_i  = 1'b0;
            right_i = 1'b1;
        end
        right_i = 1'b0;
    endtask

    task automatic test_both_pressed();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            up_i = 1'b1; tick_settle();
            up_i = 1'b0; tick_settle();
        end
        checks++;
        if (trak_o !== 8'h50) begin
            errors++;
            $display("FAIL both_setup: trak=%h want 50", trak_o);
        end
        up_i = 1'b1; down_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick_settle();
            checks++;
            if (trak_o[7:4] !== 4'd5) begin
                errors++;
                $display("FAIL both_hold%0d: v=%0d want 5", k, trak_o[7:4]);
            end
        end
        down_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick_settle();
            checks++;
            if (trak_o[7:4] !== 4'(6 + k) || v_dir_o !== 1'b0) begin
                errors++;
                $display("FAIL both_release%0d: v=%0d vdir=%b want %0d/0", k, trak_o[7:4], v_dir_o, 6 + k);
            end
        end
        up_i = 1'b0;
    endtask

    task automatic test_disable();
        do_reset();
        right_i = 1'b1;
        repeat (4) tick_settle();
        enable_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_settle();
            checks++;
            if (trak_o !== 8'h06 || h_dir_o !== 1'b0) begin
                errors++;
                $display("FAIL disable_freeze%0d: trak=%h want 06", k, trak_o);
            end
        end
        enable_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick_settle();
            checks++;
            if (trak_o !== 8'(7 + k)) begin
                errors++;
                $display("FAIL disable_resume%0d: trak=%h want %h", k, trak_o, 8'(7 + k));
            end
        end
        right_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        right_i = 1'b1;
        repeat (5) tick_settle();
        checks++;
        if (trak_o !== 8'h09) begin
            errors++;
            $display("FAIL resetmid_setup: trak=%h want 09", trak_o);
        end
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({trak_o, h_dir_o, v_dir_o, tick_o} !== 11'h0) begin
            errors++;
            $display("FAIL resetmid_async: got %h want 000", {trak_o, h_dir_o, v_dir_o, tick_o});
        end
        right_i = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        // Released at a falling edge: the prescaler hits its last count after three rising edges.
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk_sys);
            checks++;
            if (tick_o !== (n == 3) || trak_o !== 8'h00) begin
                errors++;
                $display("FAIL resetmid_restart%0d: tick=%b trak=%h want %b/00", n, tick_o, trak_o, n == 3);
            end
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_sys);
            checks++;
            if ({trak_o, h_dir_o, v_dir_o, tick_o} !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", c, {trak_o, h_dir_o, v_dir_o, tick_o}, model_vec());
            end
            if (hold_left == 0) begin
                hold_left = TICK_DIV * int'($urandom_range(1, 6)) + int'($urandom_range(0, 3));
                enable_i  = ($urandom_range(0, 7) != 0);
                left_i    = ($urandom_range(0, 2) == 0);
                right_i   = ($urandom_range(0, 2) == 0);
                up_i      = ($urandom_range(0, 2) == 0);
                down_i    = ($urandom_range(0, 2) == 0);
            end else begin
                hold_left--;
            end
        end
        {enable_i, left_i, right_i, up_i, down_i} = 5'b10000;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_accel();
        test_reversal();
        test_both_pressed();
        test_disable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
